// File: rtl/aurora_link_if.sv
// Status and control bundle between the Aurora core environment and the link monitor.
// The environment side (master) drives channel status and receives resets and counters.
interface aurora_link_if;
    logic        channel_up_i;
    logic        hard_err_i;
    logic        soft_err_i;
    logic        retrain_i;
    logic        gt_rst_o;
    logic        link_rst_o;
    logic        link_ok_o;
    logic        fault_o;
    logic [2:0]  state_o;
    logic [7:0]  retry_cnt_o;
    logic [15:0] drop_cnt_o;
    logic [15:0] soft_err_cnt_o;

    modport master (
        output channel_up_i, hard_err_i, soft_err_i, retrain_i,
        input  gt_rst_o, link_rst_o, link_ok_o, fault_o,
        input  state_o, retry_cnt_o, drop_cnt_o, soft_err_cnt_o
    );

    modport slave (
        input  channel_up_i, hard_err_i, soft_err_i, retrain_i,
        output gt_rst_o, link_rst_o, link_ok_o, fault_o,
        output state_o, retry_cnt_o, drop_cnt_o, soft_err_cnt_o
    );
endinterface

// File: rtl/aurora_link_monitor.sv
// Aurora bring-up sequencer: GT/link reset hold, channel-up wait, drop filtering, retry/fault.
// All outputs registered, reflecting the state entered on the same edge; no backpressure.
module aurora_link_monitor #(
    parameter int GT_HOLD     = 256,
    parameter int RST_HOLD    = 128,
    parameter int UP_TIMEOUT  = 2000000,
    parameter int DOWN_FILTER = 16,
    parameter int MAX_RETRY   = 8
) (
    input  logic          clk_100m,
    input  logic          rst_100m,
    aurora_link_if.slave  lnk
);

    typedef enum logic [2:0] {
        S_RESET_GT   = 3'd0,
        S_RESET_LINK = 3'd1,
        S_WAIT_UP    = 3'd2,
        S_UP         = 3'd3,
        S_FAULT      = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] flt_q, flt_d;
    logic [7:0]  retry_q, retry_d;
    logic [15:0] drop_q, drop_d;
    logic [15:0] serr_q, serr_d;
    logic        gt_rst_q, gt_rst_d;
    logic        link_rst_q, link_rst_d;
    logic        link_ok_q, link_ok_d;
    logic        fault_q, fault_d;

    logic        fail;
    logic        drop_evt;
    logic        restart;

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        drop_d   = drop_q;
        serr_d   = serr_q;
        flt_d    = '0;
        fail     = 1'b0;
        drop_evt = 1'b0;
        restart  = 1'b0;

        case (state_q)
            S_RESET_GT: begin
                if (cnt_q == 32'(GT_HOLD - 1)) state_d = S_RESET_LINK;
            end
            S_RESET_LINK: begin
                if (cnt_q == 32'(RST_HOLD - 1)) state_d = S_WAIT_UP;
            end
            S_WAIT_UP: begin
                if (lnk.hard_err_i) begin
                    fail = 1'b1;
                end else if (lnk.channel_up_i) begin
                    state_d = S_UP;
                    retry_d = '0;
                end else if (cnt_q == 32'(UP_TIMEOUT - 1)) begin
                    fail = 1'b1;
                end
            end
            S_UP: begin
                if (!lnk.channel_up_i) flt_d = flt_q + 32'd1;
                drop_evt = lnk.hard_err_i ||
                           (!lnk.channel_up_i && flt_q == 32'(DOWN_FILTER - 1));
                fail     = drop_evt;
                if (lnk.soft_err_i && serr_q != 16'hFFFF) serr_d = serr_q + 16'd1;
            end
            S_FAULT: begin
            end
            default: state_d = S_RESET_GT;
        endcase

        if (drop_evt && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;

        if (fail) begin
            if (retry_q == 8'(MAX_RETRY)) begin
                state_d = S_FAULT;
            end else begin
                retry_d = retry_q + 8'd1;
                state_d = S_RESET_GT;
                restart = 1'b1;
            end
        end

        // Manual retrain wins over any failure decision made above.
        if (lnk.retrain_i) begin
            state_d = S_RESET_GT;
            retry_d = '0;
            restart = 1'b1;
        end

        if (restart || state_d != state_q) cnt_d = '0;
        else if (cnt_q != '1)              cnt_d = cnt_q + 32'd1;
        else                               cnt_d = cnt_q;

        gt_rst_d   = (state_d == S_RESET_GT) || (state_d == S_FAULT);
        link_rst_d = (state_d == S_RESET_GT) || (state_d == S_RESET_LINK) ||
                     (state_d == S_FAULT);
        link_ok_d  = (state_d == S_UP);
        fault_d    = (state_d == S_FAULT);
    end

    always_ff @(posedge clk_100m) begin
        if (rst_100m) begin
            state_q    <= S_RESET_GT;
            cnt_q      <= '0;
            flt_q      <= '0;
            retry_q    <= '0;
            drop_q     <= '0;
            serr_q     <= '0;
            gt_rst_q   <= 1'b1;
            link_rst_q <= 1'b1;
            link_ok_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flt_q      <= flt_d;
            retry_q    <= retry_d;
            drop_q     <= drop_d;
            serr_q     <= serr_d;
            gt_rst_q   <= gt_rst_d;
            link_rst_q <= link_rst_d;
            link_ok_q  <= link_ok_d;
            fault_q    <= fault_d;
        end
    end

    assign lnk.gt_rst_o       = gt_rst_q;
    assign lnk.link_rst_o     = link_rst_q;
    assign lnk.link_ok_o      = link_ok_q;
    assign lnk.fault_o        = fault_q;
    assign lnk.state_o        = state_q;
    assign lnk.retry_cnt_o    = retry_q;
    assign lnk.drop_cnt_o     = drop_q;
    assign lnk.soft_err_cnt_o = serr_q;

endmodule

// File: tb/tb_aurora_link_monitor.sv
// Directed bench for aurora_link_monitor with small hold/timeout parameters.
// Stimulus pushes hand-computed expectations into a queue; a negedge monitor pops and compares.
module tb_aurora_link_monitor;

    logic clk_100m = 1'b0;
    logic rst_100m;

    always #5 clk_100m = ~clk_100m;

    aurora_link_if lnk();

    aurora_link_monitor #(
        .GT_HOLD     (4),
        .RST_HOLD    (3),
        .UP_TIMEOUT  (20),
        .DOWN_FILTER (2),
        .MAX_RETRY   (2)
    ) dut (
        .clk_100m (clk_100m),
        .rst_100m (rst_100m),
        .lnk      (lnk)
    );

    typedef struct {
        string       nm;
        int          due;
        logic [2:0]  st;
        logic        gt;
        logic        lr;
        logic        ok;
        logic        ft;
        logic [7:0]  rt;
        logic [15:0] dr;
        logic [15:0] se;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk_100m) cyc <= cyc + 1;

    always @(negedge clk_100m) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            tests++;
            if ({lnk.state_o, lnk.gt_rst_o, lnk.link_rst_o, lnk.link_ok_o, lnk.fault_o,
                 lnk.retry_cnt_o, lnk.drop_cnt_o, lnk.soft_err_cnt_o} !==
                {cur.st, cur.gt, cur.lr, cur.ok, cur.ft, cur.rt, cur.dr, cur.se}) begin
                fails++;
                $display("FAIL %s: got st=%0d gt=%b lr=%b ok=%b flt=%b retry=%0d drop=%0d serr=%0d, expected st=%0d gt=%b lr=%b ok=%b flt=%b retry=%0d drop=%0d serr=%0d",
                         cur.nm, lnk.state_o, lnk.gt_rst_o, lnk.link_rst_o, lnk.link_ok_o,
                         lnk.fault_o, lnk.retry_cnt_o, lnk.drop_cnt_o, lnk.soft_err_cnt_o,
                         cur.st, cur.gt, cur.lr, cur.ok, cur.ft, cur.rt, cur.dr, cur.se);
            end
        end
    end

    task automatic push_exp(input string nm, input logic [2:0] st, input logic gt,
                            input logic lr, input logic ok, input logic ft,
                            input logic [7:0] rt, input logic [15:0] dr, input logic [15:0] se);
        exp_t e;
        e.nm = nm; e.due = cyc; e.st = st; e.gt = gt; e.lr = lr; e.ok = ok; e.ft = ft;
        e.rt = rt; e.dr = dr; e.se = se;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_100m);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_100m         = 1'b1;
        lnk.channel_up_i = 1'b1;
        lnk.hard_err_i   = 1'b0;
        lnk.soft_err_i   = 1'b0;
        lnk.retrain_i    = 1'b0;
        step(3);
        push_exp("reset", 0, 1, 1, 0, 0, 0, 0, 0);

        // Bring-up: 4 cycles GT reset, 3 more link reset, then WAIT_UP, then UP.
        rst_100m = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_exp("rgt_hold", 0, 1, 1, 0, 0, 0, 0, 0);
            step(1);
        end
        for (int i = 0; i < 3; i++) begin
            push_exp("rlink_hold", 1, 0, 1, 0, 0, 0, 0, 0);
            step(1);
        end
        push_exp("wait_up", 2, 0, 0, 0, 0, 0, 0, 0);
        step(1);
        push_exp("up", 3, 0, 0, 1, 0, 0, 0, 0);

        // One-cycle glitch is filtered; two low cycles declare a drop.
        lnk.channel_up_i = 1'b0;
        step(1);
        lnk.channel_up_i = 1'b1;
        step(2);
        push_exp("glitch_no_drop", 3, 0, 0, 1, 0, 0, 0, 0);
        lnk.channel_up_i = 1'b0;
        step(1);
        push_exp("drop_filter_half", 3, 0, 0, 1, 0, 0, 0, 0);
        step(1);
        push_exp("drop", 0, 1, 1, 0, 0, 1, 1, 0);
        lnk.channel_up_i = 1'b1;
        step(7);
        push_exp("rerun_wait", 2, 0, 0, 0, 0, 1, 1, 0);
        step(1);
        push_exp("rerun_up", 3, 0, 0, 1, 0, 0, 1, 0);

        // Soft errors counted only in UP; hard error forces a restart.
        lnk.soft_err_i = 1'b1;
        step(5);
        lnk.soft_err_i = 1'b0;
        push_exp("soft_cnt", 3, 0, 0, 1, 0, 0, 1, 5);
        lnk.hard_err_i = 1'b1;
        step(1);
        lnk.hard_err_i = 1'b0;
        push_exp("hard_err", 0, 1, 1, 0, 0, 1, 2, 5);
        lnk.soft_err_i = 1'b1;
        step(7);
        push_exp("soft_outside_up", 2, 0, 0, 0, 0, 1, 2, 5);
        step(1);
        lnk.soft_err_i = 1'b0;
        push_exp("hard_rerun_up", 3, 0, 0, 1, 0, 0, 2, 5);

        // Reset from UP, then channel never comes up: three timeouts then FAULT.
        rst_100m         = 1'b1;
        lnk.channel_up_i = 1'b0;
        step(1);
        push_exp("reset_mid", 0, 1, 1, 0, 0, 0, 0, 0);
        rst_100m = 1'b0;
        step(7);
        push_exp("to1_wait", 2, 0, 0, 0, 0, 0, 0, 0);
        step(19);
        push_exp("to1_edge", 2, 0, 0, 0, 0, 0, 0, 0);
        step(1);
        push_exp("to1_fail", 0, 1, 1, 0, 0, 1, 0, 0);
        step(26);
        push_exp("to2_edge", 2, 0, 0, 0, 0, 1, 0, 0);
        step(1);
        push_exp("to2_fail", 0, 1, 1, 0, 0, 2, 0, 0);
        step(27);
        push_exp("to3_fault", 4, 1, 1, 0, 1, 2, 0, 0);
        step(5);
        push_exp("fault_hold", 4, 1, 1, 0, 1, 2, 0, 0);

        // Retrain out of FAULT reruns the full sequence.
        lnk.channel_up_i = 1'b1;
        lnk.retrain_i    = 1'b1;
        step(1);
        lnk.retrain_i = 1'b0;
        push_exp("retrain", 0, 1, 1, 0, 0, 0, 0, 0);
        step(4);
        push_exp("retrain_rlink", 1, 0, 1, 0, 0, 0, 0, 0);
        step(3);
        push_exp("retrain_wait", 2, 0, 0, 0, 0, 0, 0, 0);
        step(1);
        push_exp("retrain_up", 3, 0, 0, 1, 0, 0, 0, 0);

        // Retrain coinciding with a WAIT_UP timeout clears retry instead of incrementing.
        lnk.channel_up_i = 1'b0;
        step(2);
        push_exp("drop_again", 0, 1, 1, 0, 0, 1, 1, 0);
        step(26);
        push_exp("tmo_edge", 2, 0, 0, 0, 0, 1, 1, 0);
        lnk.retrain_i = 1'b1;
        step(1);
        lnk.retrain_i = 1'b0;
        push_exp("retrain_vs_timeout", 0, 1, 1, 0, 0, 0, 1, 0);
        step(3);
        push_exp("rgt_restart_hold", 0, 1, 1, 0, 0, 0, 1, 0);
        step(1);
        push_exp("rgt_restart_exit", 1, 0, 1, 0, 0, 0, 1, 0);

        step(2);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
            fails = fails + sb.size();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aurora_link_monitor.md
AURORA_LINK_MONITOR -- requirements
Module: aurora_link_monitor

Interface
REQ-001 Parameter GT_HOLD, default 256, cycles gt_rst_o and link_rst_o are held together per reset attempt.
REQ-002 Parameter RST_HOLD, default 128, extra cycles link_rst_o stays high after gt_rst_o falls.
REQ-003 Parameter UP_TIMEOUT, default 2000000, cycles (20 ms) allowed for channel_up_i after link_rst_o falls.
REQ-004 Parameter DOWN_FILTER, default 16, consecutive cycles channel_up_i must be low in UP before a drop is declared.
REQ-005 Parameter MAX_RETRY, default 8, consecutive failed attempts tolerated before FAULT.
REQ-006 clk_100m  in  1  sole clock; all logic on its rising edge.
REQ-007 rst_100m  in  1  synchronous, active-high reset.
REQ-008 channel_up_i  in  1  Aurora channel up, already synchronous to clk_100m.
REQ-009 hard_err_i  in  1  Aurora hard error, synchronous, level.
REQ-010 soft_err_i  in  1  Aurora soft error, synchronous, one count per high cycle.
REQ-011 retrain_i  in  1  single-cycle manual re-initialisation request.
REQ-012 gt_rst_o  out  1  GT reset to the Aurora core, active-high.
REQ-013 link_rst_o  out  1  Aurora reset_pb, active-high.
REQ-014 link_ok_o  out  1  high only in state UP.
REQ-015 fault_o  out  1  high only in state FAULT.
REQ-016 state_o  out  3  0 RESET_GT, 1 RESET_LINK, 2 WAIT_UP, 3 UP, 4 FAULT.
REQ-017 retry_cnt_o  out  8  consecutive failed attempts.
REQ-018 drop_cnt_o  out  16  total declared link drops, saturating.
REQ-019 soft_err_cnt_o  out  16  soft errors counted in UP, saturating.

Function
REQ-020 A single state counter shall clear on every state entry and advance once per cycle within a state.
REQ-021 RESET_GT: gt_rst_o=1 and link_rst_o=1; exit to RESET_LINK after exactly GT_HOLD cycles.
REQ-022 RESET_LINK: gt_rst_o=0 and link_rst_o=1; exit to WAIT_UP after exactly RST_HOLD cycles.
REQ-023 WAIT_UP: both resets 0; channel_up_i=1 and hard_err_i=0 -> UP next cycle, retry_cnt_o cleared.
REQ-024 WAIT_UP failure: counter reaching UP_TIMEOUT-1 without channel_up_i, or hard_err_i=1 in any cycle.
REQ-025 UP: a drop is channel_up_i low for DOWN_FILTER consecutive cycles (filter counter clears when channel_up_i returns high), or hard_err_i=1 in any cycle.
REQ-026 Each drop shall increment drop_cnt_o, saturating at 0xFFFF, and count as a failure.
REQ-027 On a failure, if retry_cnt_o equals MAX_RETRY, the next state shall be FAULT; otherwise retry_cnt_o increments and the next state is RESET_GT.
REQ-028 FAULT: gt_rst_o=1 and link_rst_o=1 held; state persists until retrain_i or rst_100m.
REQ-029 retrain_i in any state -> RESET_GT next cycle with retry_cnt_o cleared; it overrides a failure in the same cycle.
REQ-030 soft_err_cnt_o shall increment in each UP cycle with soft_err_i=1, saturating at 0xFFFF; it is cleared by reset only.
REQ-031 All outputs shall be registered; state_o, link_ok_o and fault_o change on the same edge as the state.

Reset
REQ-032 While rst_100m=1: state RESET_GT, counters 0, gt_rst_o=1, link_rst_o=1, link_ok_o=0, fault_o=0, retry_cnt_o=0, drop_cnt_o=0, soft_err_cnt_o=0.
REQ-033 After rst_100m falls, RESET_GT shall last exactly GT_HOLD cycles; reset asserted mid-sequence restarts from REQ-032 on the next edge.

Verification (GT_HOLD=4, RST_HOLD=3, UP_TIMEOUT=20, DOWN_FILTER=2, MAX_RETRY=2)
REQ-034 Release reset with channel_up_i=1 -> gt_rst_o high for 4 cycles, link_rst_o high for 7 cycles, link_ok_o=1 one cycle after WAIT_UP entry.
REQ-035 In UP, pulse channel_up_i low for 1 cycle -> no drop; hold it low for 2 cycles -> drop_cnt_o=1, state_o=0, retry_cnt_o=1.
REQ-036 Hold channel_up_i=0 -> three timeouts of 20 cycles each, with retry_cnt_o going 1, 2; on the third failure state_o=4, fault_o=1, both resets high.
REQ-037 In FAULT, pulse retrain_i -> state_o=0, retry_cnt_o=0, and the full sequence reruns.
REQ-038 In UP, drive soft_err_i high for 5 cycles -> soft_err_cnt_o=5; hard_err_i=1 for one cycle -> state_o=0 next cycle.
REQ-039 retrain_i together with a WAIT_UP timeout in the same cycle -> RESET_GT with retry_cnt_o=0, not incremented.
